matrix_keypad_scanner: RTL and testbench
========================================

MATRIX_KEYPAD_SCANNER -- requirements
Module: matrix_keypad_scanner

Interface
REQ-001 SHALL provide parameter ROWS, default 4, number of row inputs (2..8).
REQ-002 SHALL provide parameter COLS, default 4, number of column drives (2..8).
REQ-003 SHALL provide parameter SCAN_DIV, default 50000, clocks per column dwell (>= 8*ROWS).
REQ-004 SHALL provide parameter DEB_SAMPLES, default 4, row samples per dwell (2..8).
REQ-005 SHALL provide parameter FIFO_DEPTH, default 4, event queue depth (power of 2, >= 2).
REQ-006 SHALL provide parameters REPEAT_DELAY, default 16, and REPEAT_RATE, default 4, in scan frames.
REQ-007 SHALL use one clock, clk; reset rst is asynchronous and active-low.
REQ-008 Ports: clk input 1, system clock; rst input 1, async active-low reset.
REQ-009 Ports: c_pin output COLS, one-hot active-high column drive; r_pin input ROWS, active-high row sense.
REQ-010 Ports: key_valid output 1, event available; key_ready input 1, consumer accepts event.
REQ-011 Ports: key_code output KW=clog2(ROWS*COLS), code = col*ROWS + row; key_press output 1, 1 press / 0 release.
REQ-012 Ports: key_repeat output 1, event is auto-repeat; key_state output ROWS*COLS, debounced map, bit = code.
REQ-013 Ports: ovf output 1, one-cycle pulse when an event is dropped.

Function
REQ-014 Dwell counter SHALL count 0..SCAN_DIV-1; column index SHALL advance 0..COLS-1 and wrap at terminal count; one full wrap = one frame.
REQ-015 c_pin SHALL equal one-hot(column index) throughout each dwell.
REQ-016 Row sampling SHALL occur at DEB_SAMPLES points evenly spaced in the second half of the dwell, into a per-row shift buffer cleared at dwell start.
REQ-017 At the last dwell cycle, per row: all samples 1 -> key pressed; all 0 -> released; mixed -> key_state bit unchanged.
REQ-018 Each changed key_state bit SHALL generate one event; multiple changes in one column SHALL be enqueued one per cycle, lowest row first, completing within ROWS+1 cycles.
REQ-019 Events SHALL pass through a FIFO_DEPTH FIFO; key_valid = FIFO not empty; transfer occurs when key_valid && key_ready; key_code/key_press/key_repeat SHALL be stable while key_valid && !key_ready.
REQ-020 First event SHALL appear on key_valid no later than ROWS+2 cycles after the deciding dwell end.
REQ-021 Push to full FIFO SHALL drop the event and pulse ovf; a simultaneous pop and push when full SHALL both succeed with no ovf.
REQ-022 key_state SHALL update regardless of FIFO occupancy.

Reset
REQ-023 While rst low: c_pin = one-hot column 0, key_state = 0, FIFO empty, key_valid = 0, key_code = 0, key_press = 0, key_repeat = 0, ovf = 0, counters = 0, repeat timer idle.
REQ-024 Reset asserted mid-dwell or mid-enqueue SHALL discard pending samples and events; after release, scanning SHALL restart at column 0, count 0.

Configuration
REQ-025 Macro KEYPAD_REPEAT_EN SHALL compile in auto-repeat.
REQ-026 With KEYPAD_REPEAT_EN: most recently pressed key, while held, SHALL emit a press event with key_repeat=1 after REPEAT_DELAY frames, then every REPEAT_RATE frames; timer cancels on its release or on any new press.
REQ-027 Without KEYPAD_REPEAT_EN: no repeat logic, key_repeat tied 0, REPEAT_* parameters ignored.

Structure
REQ-028 Package keypad_pkg SHALL hold event struct (code, press, repeat), code-width function, and default parameter constants.
REQ-029 Sub-module keypad_debounce SHALL implement one row's sample buffer and decision; instantiated ROWS times.

Verification (SCAN_DIV=64, ROWS=COLS=4, DEB_SAMPLES=4, FIFO_DEPTH=4)
REQ-030 Hold r_pin[2]=1 only while c_pin=4'b0010, key_ready=1 -> one event code 6, press=1; key_state[6]=1; release -> code 6, press=0.
REQ-031 r_pin[1] toggling between samples for 3 frames -> no events, key_state unchanged.
REQ-032 Rows 0 and 3 pressed in column 2, key_ready=0 -> codes 8 then 11 queued in order; key_valid held, outputs stable until ready.
REQ-033 key_ready=0, 5 distinct presses -> 4 events queued, ovf pulses exactly once, codes retained in order.
REQ-034 rst pulsed low mid-dwell of column 3 with key held -> all outputs reset values; c_pin=4'b0001 after release; press re-detected in first frame.
REQ-035 KEYPAD_REPEAT_EN, REPEAT_DELAY=2, REPEAT_RATE=1, key 0 held 6 frames -> one press plus repeat events with key_repeat=1 at frames 2,3,4,5.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared event type, code-width helper and default parameter values for the
// matrix keypad scanner.
package keypad_pkg;

   localparam int DEF_ROWS         = 4;
   localparam int DEF_COLS         = 4;
   localparam int DEF_SCAN_DIV     = 50000;
   localparam int DEF_DEB_SAMPLES  = 4;
   localparam int DEF_FIFO_DEPTH   = 4;
   localparam int DEF_REPEAT_DELAY = 16;
   localparam int DEF_REPEAT_RATE  = 4;

   // Widest code an 8x8 matrix can produce; narrower builds use the low bits.
   localparam int MAX_KW = 6;

   typedef struct packed {
      logic [MAX_KW-1:0] code;
      logic              press;
      logic              rpt;
   } key_event_t;

   function automatic int code_width(input int rows, input int cols);
      return (rows * cols <= 2) ? 1 : $clog2(rows * cols);
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// One row's sample buffer: cleared at dwell start, shifted at each sample
// point, and reduced to an all-ones / all-zeros decision.
module keypad_debounce #(
   parameter int DEB_SAMPLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic smp,
   input  logic row,
   output logic all_one,
   output logic all_zero
);

   logic [DEB_SAMPLES-1:0] buf_q;
   logic [DEB_SAMPLES-1:0] buf_d;

   always_comb begin
      // NOTE: default assignment first so no path leaves buf_d unassigned (no latch).
      buf_d = buf_q;
      if (clr)
         buf_d = '0;
      else if (smp)
         buf_d = {buf_q[DEB_SAMPLES-2:0], row};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         buf_q <= '0;
      else
         buf_q <= buf_d;
   end

   // Decision looks at the buffer including a sample landing this cycle.
   assign all_one  = &buf_d;
   assign all_zero = ~|buf_d;

endmodule

// File: rtl/matrix_keypad_scanner.sv
// Column-scanning keypad controller with per-row debounce and an event FIFO.
// Define KEYPAD_REPEAT_EN to compile in auto-repeat of the last pressed key.
module matrix_keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS         = DEF_ROWS,
   parameter int COLS         = DEF_COLS,
   parameter int SCAN_DIV     = DEF_SCAN_DIV,
   parameter int DEB_SAMPLES  = DEF_DEB_SAMPLES,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
   localparam int KW          = code_width(ROWS, COLS)
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [COLS-1:0]      c_pin,
   input  logic [ROWS-1:0]      r_pin,
   output logic                 key_valid,
   input  logic                 key_ready,
   output logic [KW-1:0]        key_code,
   output logic                 key_press,
   output logic                 key_repeat,
   output logic [ROWS*COLS-1:0] key_state,
   output logic                 ovf
);

   localparam int CW   = $clog2(SCAN_DIV + 1);
   localparam int CLW  = $clog2(COLS);
   localparam int RW   = $clog2(ROWS);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int HALF = SCAN_DIV / 2;
   localparam int STEP = (SCAN_DIV - HALF) / DEB_SAMPLES;

   if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || DEB_SAMPLES < 2 || DEB_SAMPLES > 8 ||
       SCAN_DIV < 8 * ROWS || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
      $error("matrix_keypad_scanner: parameter out of range");
   end

   logic [CW-1:0]   dwell_cnt, next_samp;
   logic [CLW-1:0]  col_idx;
   logic [ROWS-1:0] r_meta, r_sync;
   logic            dwell_end, dwell_start, sample_en;

   assign dwell_end   = dwell_cnt == CW'(SCAN_DIV - 1);
   assign dwell_start = dwell_cnt == '0;
   assign sample_en   = (dwell_cnt == next_samp) && (next_samp < CW'(HALF + DEB_SAMPLES * STEP));
   assign c_pin       = COLS'(1) << col_idx;

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (!rst) begin
         dwell_cnt <= '0;
         next_samp <= CW'(HALF);
         col_idx   <= '0;
         r_meta    <= '0;
         r_sync    <= '0;
      end else begin
         r_meta <= r_pin;
         r_sync <= r_meta;
         if (dwell_end) begin
            dwell_cnt <= '0;
            next_samp <= CW'(HALF);
            col_idx   <= (col_idx == CLW'(COLS - 1)) ? '0 : col_idx + 1'b1;
         end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
            if (sample_en)
               next_samp <= next_samp + CW'(STEP);
         end
      end
   end

   logic [ROWS-1:0] all_one, all_zero;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      keypad_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
         .clk      (clk),
         .rst      (rst),
         .clr      (dwell_start),
         .smp      (sample_en),
         .row      (r_sync[r]),
         .all_one  (all_one[r]),
         .all_zero (all_zero[r])
      );
   end

   logic [ROWS-1:0] old_col, new_col, chg_col, rep_hit;

   always_comb begin
      old_col = key_state[int'(col_idx) * ROWS +: ROWS];
      new_col = (old_col | all_one) & ~all_zero;
      chg_col = old_col ^ new_col;
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int TW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);

   logic           rep_active, rep_first, rep_here, rep_due;
   logic [CLW-1:0] rep_col;
   logic [RW-1:0]  rep_row, top_new;
   logic [TW-1:0]  rep_cnt;
   logic [ROWS-1:0] new_press;

   // Timer advances once per frame, when the tracked key's own column is decided.
   always_comb begin
      new_press = chg_col & new_col;
      top_new   = '0;
      for (int r = 0; r < ROWS; r++)
         if (new_press[r]) top_new = RW'(r);
      rep_here = rep_active && (rep_col == col_idx);
      rep_due  = (rep_cnt + 1'b1) == (rep_first ? TW'(REPEAT_DELAY) : TW'(REPEAT_RATE));
      rep_hit  = '0;
      if (rep_here && new_col[rep_row] && new_press == '0 && rep_due)
         rep_hit[rep_row] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_active <= 1'b0;
         rep_first  <= 1'b1;
         rep_col    <= '0;
         rep_row    <= '0;
         rep_cnt    <= '0;
      end else if (dwell_end) begin
         if (new_press != '0) begin
            rep_active <= 1'b1;
            rep_first  <= 1'b1;
            rep_col    <= col_idx;
            rep_row    <= top_new;
            rep_cnt    <= '0;
         end else if (rep_here) begin
            if (!new_col[rep_row]) begin
               rep_active <= 1'b0;
            end else if (rep_due) begin
               rep_cnt   <= '0;
               rep_first <= 1'b0;
            end else begin
               rep_cnt <= rep_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign rep_hit = '0;
`endif

   logic [ROWS-1:0] pend_mask, pend_press, pend_rep;
   logic [CLW-1:0]  pend_col;
   logic [RW-1:0]   pend_row;
   logic            push;
   key_event_t      push_ev;

   always_comb begin
      pend_row = '0;
      for (int r = ROWS - 1; r >= 0; r--)
         if (pend_mask[r]) pend_row = RW'(r);
      push          = |pend_mask;
      push_ev.code  = MAX_KW'(int'(pend_col) * ROWS + int'(pend_row));
      push_ev.press = pend_press[pend_row];
      push_ev.rpt   = pend_rep[pend_row];
   end

   // key_state follows the debounce decision whatever the FIFO is doing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_state  <= '0;
         pend_mask  <= '0;
         pend_press <= '0;
         pend_rep   <= '0;
         pend_col   <= '0;
      end else if (dwell_end) begin
         key_state[int'(col_idx) * ROWS +: ROWS] <= new_col;
         pend_mask  <= chg_col | rep_hit;
         pend_press <= new_col;
         pend_rep   <= rep_hit;
         pend_col   <= col_idx;
      end else if (push) begin
         pend_mask[pend_row] <= 1'b0;
      end
   end

   key_event_t    mem [FIFO_DEPTH];
   key_event_t    head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, pop, do_push, unused_code_bits;

   assign full    = count == (AW + 1)'(FIFO_DEPTH);
   assign pop     = key_valid && key_ready;
   assign do_push = push && (!full || pop);

   // NOTE: storage array is not reset; reads are masked by key_valid instead.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_ev;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         ovf <= push && full && !pop;
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign head             = mem[rd_ptr];
   assign key_valid        = count != '0;
   assign key_code         = key_valid ? head.code[KW-1:0] : '0;
   assign key_press        = key_valid && head.press;
   assign key_repeat       = key_valid && head.rpt;
   assign unused_code_bits = |(head.code >> KW);

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Scoreboard bench for matrix_keypad_scanner: a keypad model drives r_pin from
// c_pin, expected events are queued at stimulus time and a monitor checks them.
module tb_matrix_keypad_scanner;
   import keypad_pkg::*;

   localparam int FRAME = 4 * 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  c_pin;
   logic [3:0]  r_pin = '0;
   logic        key_valid;
   logic        key_ready = 1'b1;
   logic [3:0]  key_code;
   logic        key_press, key_repeat;
   logic [15:0] key_state;
   logic        ovf;

   always #5 clk = ~clk;

   matrix_keypad_scanner #(
      .ROWS(4), .COLS(4), .SCAN_DIV(64), .DEB_SAMPLES(4), .FIFO_DEPTH(4),
      .REPEAT_DELAY(2), .REPEAT_RATE(1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .c_pin      (c_pin),
      .r_pin      (r_pin),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_code   (key_code),
      .key_press  (key_press),
      .key_repeat (key_repeat),
      .key_state  (key_state),
      .ovf        (ovf)
   );

   typedef struct {
      int code;
      bit press;
      bit rpt;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_cmp = 0, n_err = 0, n_rx = 0, n_ovf = 0, rx0;
   logic [15:0] held = '0;
   bit          bounce = 1'b0;
   int          dwell_t = 0;
   logic [3:0]  last_c = '0, rv;
   bit          stall_prev = 1'b0;
   logic [3:0]  prev_code;
   logic        prev_press, prev_rpt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int code, input bit press, input bit rpt);
      exp_t e;
      e.code = code; e.press = press; e.rpt = rpt;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns just after the edge that starts a dwell of column `col`.
   task automatic wait_col_start(input logic [3:0] col, input string name);
      bit         seen;
      logic [3:0] pc;
      seen = 1'b0;
      pc   = c_pin;
      for (int k = 0; k < 3 * FRAME && !seen; k++) begin
         tick(1);
         if (c_pin == col && pc != col) seen = 1'b1;
         pc = c_pin;
      end
      check({name, "_sync"}, 32'(seen), 32'd1);
   endtask

   // Keypad model: a held key connects its column drive to its row sense.
   initial forever begin
      @(posedge clk);
      #1;
      if (c_pin != last_c) dwell_t = 0;
      else dwell_t++;
      last_c = c_pin;
      rv = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (c_pin[c] && held[c * 4 + r]) rv[r] = 1'b1;
      if (bounce && c_pin[0]) rv[1] = (dwell_t < 42);
      r_pin = rv;
   end

   // Monitor: pops the scoreboard on each transfer and checks stall stability.
   initial forever begin
      @(negedge clk);
      if (ovf) n_ovf++;
      if (stall_prev && key_valid) begin
         check("hold_code", 32'(key_code), 32'(prev_code));
         check("hold_press", 32'(key_press), 32'(prev_press));
         check("hold_repeat", 32'(key_repeat), 32'(prev_rpt));
      end
      stall_prev = key_valid && !key_ready && rst;
      prev_code  = key_code;
      prev_press = key_press;
      prev_rpt   = key_repeat;
      if (key_valid && key_ready) begin
         n_rx++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got code %0d press %0b repeat %0b, expected none",
                     key_code, key_press, key_repeat);
         end else begin
            mon_e = exp_q.pop_front();
            check("ev_code", 32'(key_code), 32'(mon_e.code));
            check("ev_press", 32'(key_press), 32'(mon_e.press));
            check("ev_repeat", 32'(key_repeat), 32'(mon_e.rpt));
         end
      end
   end

   initial begin
      #600_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      tick(3);
      check("rst_c_pin", 32'(c_pin), 32'h1);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_code", 32'(key_code), 32'h0);
      check("rst_press", 32'(key_press), 32'h0);
      check("rst_repeat", 32'(key_repeat), 32'h0);
      check("rst_state", 32'(key_state), 32'h0);
      check("rst_ovf", 32'(ovf), 32'h0);
      rst = 1'b1;

      // Single key at column 1, row 2.
      held[6] = 1'b1;
      push_exp(6, 1'b1, 1'b0);
      tick(2 * FRAME);
      check("single_state", 32'(key_state), 32'h0040);
      held[6] = 1'b0;
      push_exp(6, 1'b0, 1'b0);
      tick(2 * FRAME);
      check("single_release_state", 32'(key_state), 32'h0);
      check("single_rx", 32'(n_rx), 32'd2);

      // Bouncing contact on row 1 of column 0.
      rx0 = n_rx;
      bounce = 1'b1;
      tick(3 * FRAME);
      bounce = 1'b0;
      tick(FRAME);
      check("bounce_state", 32'(key_state), 32'h0);
      check("bounce_rx", 32'(n_rx - rx0), 32'd0);

      // Two keys in one column while the consumer stalls.
      key_ready = 1'b0;
      held[8] = 1'b1;
      held[11] = 1'b1;
      push_exp(8, 1'b1, 1'b0);
      push_exp(11, 1'b1, 1'b0);
      tick(2 * FRAME);
      check("pair_valid", 32'(key_valid), 32'h1);
      check("pair_head", 32'(key_code), 32'd8);
      check("pair_state", 32'(key_state), 32'h0900);
      rx0 = n_rx;
      key_ready = 1'b1;
      tick(4);
      check("pair_rx", 32'(n_rx - rx0), 32'd2);
      check("pair_empty", 32'(key_valid), 32'h0);
      held[8] = 1'b0;
      held[11] = 1'b0;
      push_exp(8, 1'b0, 1'b0);
      push_exp(11, 1'b0, 1'b0);
      tick(2 * FRAME);

      // Five presses into a four-deep queue.
      check("pre_ovf_cnt", 32'(n_ovf), 32'd0);
      key_ready = 1'b0;
      wait_col_start(4'b0001, "ovf_press");
      held = 16'h8429;
      push_exp(0, 1'b1, 1'b0);
      push_exp(3, 1'b1, 1'b0);
      push_exp(5, 1'b1, 1'b0);
      push_exp(10, 1'b1, 1'b0);
      tick(FRAME + 8);
      check("ovf_cnt", 32'(n_ovf), 32'd1);
      check("ovf_state", 32'(key_state), 32'h8429);
      check("ovf_head", 32'(key_code), 32'd0);
      rx0 = n_rx;
      key_ready = 1'b1;
      tick(6);
      check("ovf_rx", 32'(n_rx - rx0), 32'd4);
      wait_col_start(4'b0001, "ovf_release");
      held = '0;
      push_exp(0, 1'b0, 1'b0);
      push_exp(3, 1'b0, 1'b0);
      push_exp(5, 1'b0, 1'b0);
      push_exp(10, 1'b0, 1'b0);
      push_exp(15, 1'b0, 1'b0);
      tick(FRAME + 8);
      check("ovf_release_state", 32'(key_state), 32'h0);

      // Reset in the middle of a column-3 dwell with key 13 held.
      held[13] = 1'b1;
      push_exp(13, 1'b1, 1'b0);
      tick(2 * FRAME);
      check("pre_rst_state", 32'(key_state), 32'h2000);
      wait_col_start(4'b1000, "rst_col3");
      tick(20);
      rst = 1'b0;
      #2;
      check("mid_rst_c_pin", 32'(c_pin), 32'h1);
      check("mid_rst_state", 32'(key_state), 32'h0);
      check("mid_rst_valid", 32'(key_valid), 32'h0);
      check("mid_rst_code", 32'(key_code), 32'h0);
      check("mid_rst_press", 32'(key_press), 32'h0);
      check("mid_rst_ovf", 32'(ovf), 32'h0);
      tick(3);
      rst = 1'b1;
      tick(1);
      check("post_rst_c_pin", 32'(c_pin), 32'h1);
      rx0 = n_rx;
      push_exp(13, 1'b1, 1'b0);
      tick(FRAME + 8);
      check("redetect_state", 32'(key_state), 32'h2000);
      check("redetect_rx", 32'(n_rx - rx0), 32'd1);
      held[13] = 1'b0;
      push_exp(13, 1'b0, 1'b0);
      tick(2 * FRAME);

`ifdef KEYPAD_REPEAT_EN
      // Key 0 held through six column-0 decisions: press, repeats, release.
      rx0 = n_rx;
      wait_col_start(4'b0001, "rep_start");
      held[0] = 1'b1;
      push_exp(0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) push_exp(0, 1'b1, 1'b1);
      push_exp(0, 1'b0, 1'b0);
      tick(5 * FRAME + 128);
      held[0] = 1'b0;
      tick(2 * FRAME);
      check("repeat_rx", 32'(n_rx - rx0), 32'd6);
`endif

      tick(20);
      check("drain", 32'(exp_q.size()), 32'd0);
      check("ovf_total", 32'(n_ovf), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
